// File: rtl/integral_peak_finder.sv
// Pulse peak detector downstream of gated_integrator: threshold trigger, track to
// maximum, emit (peak, timestamp) records through a one-deep valid/ready register.
module integral_peak_finder #(
    parameter int unsigned P_NBITS_SUM  = 20,
    parameter int unsigned P_NBITS_TIME = 32,
    parameter int unsigned P_NBITS_HOLD = 8,
    parameter int unsigned P_NBITS_DROP = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [P_NBITS_SUM-1:0]  sum,
    input  logic                    sum_valid,
    input  logic [P_NBITS_SUM-1:0]  thresh,
    input  logic [P_NBITS_HOLD-1:0] holdoff,
    output logic [P_NBITS_SUM-1:0]  pk_val,
    output logic [P_NBITS_TIME-1:0] pk_time,
    output logic                    pk_valid,
    input  logic                    pk_rdy,
    output logic                    busy,
    output logic [P_NBITS_DROP-1:0] drop_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TRACK = 2'd1,
        S_HOLD  = 2'd2,
        S_REARM = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [P_NBITS_TIME-1:0] ts_q;
    logic [P_NBITS_SUM-1:0]  max_q, max_d;
    logic [P_NBITS_TIME-1:0] tmax_q, tmax_d;
    logic [P_NBITS_HOLD-1:0] cnt_q, cnt_d;
    logic [P_NBITS_SUM-1:0]  pk_val_q, pk_val_d;
    logic [P_NBITS_TIME-1:0] pk_time_q, pk_time_d;
    logic                    pk_valid_q, pk_valid_d;
    logic [P_NBITS_DROP-1:0] drop_q, drop_d;
    logic                    busy_q;
    logic                    emit_c;
    logic                    load_c;

    // State, tracking and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ts_q       <= '0;
            max_q      <= '0;
            tmax_q     <= '0;
            cnt_q      <= '0;
            pk_val_q   <= '0;
            pk_time_q  <= '0;
            pk_valid_q <= 1'b0;
            drop_q     <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ts_q       <= ts_q + P_NBITS_TIME'(1);
            max_q      <= max_d;
            tmax_q     <= tmax_d;
            cnt_q      <= cnt_d;
            pk_val_q   <= pk_val_d;
            pk_time_q  <= pk_time_d;
            pk_valid_q <= pk_valid_d;
            drop_q     <= drop_d;
            busy_q     <= (state_d != S_IDLE);
        end
    end

    // Trigger / track / holdoff / re-arm sequencing
    always_comb begin
        state_d = state_q;
        max_d   = max_q;
        tmax_d  = tmax_q;
        cnt_d   = cnt_q;
        emit_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sum_valid && (sum >= thresh)) begin
                    state_d = S_TRACK;
                    max_d   = sum;
                    tmax_d  = ts_q;
                end
            end
            S_TRACK: begin
                // Ties keep the earliest timestamp; threshold is ignored while tracking
                if (!sum_valid) begin
                    state_d = S_IDLE;
                end else if (sum > max_q) begin
                    max_d  = sum;
                    tmax_d = ts_q;
                end else if (sum < max_q) begin
                    emit_c  = 1'b1;
                    state_d = S_HOLD;
                    cnt_d   = holdoff;
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_REARM;
                end else begin
                    cnt_d = cnt_q - P_NBITS_HOLD'(1);
                end
            end
            S_REARM: begin
                if (!sum_valid || (sum < thresh)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output register: accept-and-reload in one cycle, otherwise drop and count
    always_comb begin
        pk_val_d   = pk_val_q;
        pk_time_d  = pk_time_q;
        pk_valid_d = pk_valid_q;
        drop_d     = drop_q;
        load_c     = emit_c && (!pk_valid_q || pk_rdy);
        if (pk_valid_q && pk_rdy) begin
            pk_valid_d = 1'b0;
        end
        if (load_c) begin
            pk_val_d   = max_q;
            pk_time_d  = tmax_q;
            pk_valid_d = 1'b1;
        end else if (emit_c && (drop_q != '1)) begin
            drop_d = drop_q + P_NBITS_DROP'(1);
        end
    end

    assign pk_val   = pk_val_q;
    assign pk_time  = pk_time_q;
    assign pk_valid = pk_valid_q;
    assign busy     = busy_q;
    assign drop_cnt = drop_q;

endmodule
